ps2_host_tx: RTL

PS/2 host-to-device transmitter, the transmit side of the existing keyboard decode path. It sends one command byte to the keyboard, for example 0xED (set LEDs) or 0xFF (reset). Both PS2_CLK and PS2_DATA are driven open-drain through output enables; the top level ties each line to 1'bz when its enable is 0 and to 1'b0 when it is 1. While busy is high the keyboard receive path ignores the bus.

---
 rtl/ps2_pkg.sv | 33 +++
 rtl/ps2_line_filter.sv | 61 ++++++
 rtl/ps2_host_tx.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 host transmitter.
//   state_e      - transmitter FSM states
//   ERR_*        - err_code encodings
//   CMD_*        - common keyboard command bytes
//   odd_parity() - PS/2 frame parity bit for a data byte
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        START     = 3'd2,
        BITS      = 3'd3,
        WAIT_IDLE = 3'd4,
        ERR       = 3'd5
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_NOACK   = 2'd2;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ECHO    = 8'hEE;
    localparam logic [7:0] CMD_RESET   = 8'hFF;

    // Retries after the first failed attempt (retry build only).
    localparam logic [1:0] MAX_RETRIES = 2'd2;

    // Parity bit that makes the 9-bit data+parity field have an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: conditions one raw PS/2 pad line.
// 2-FF synchronizer, then a glitch filter that only changes the filtered level
// after FILTER_LEN consecutive synchronized samples disagree with it, plus a
// one-cycle pulse on every filtered high-to-low transition.
// Ports:
//   clk, rst - clock, asynchronous active-low reset (lines idle high)
//   pad_in   - raw pad level
//   level    - filtered line level
//   fall     - one-cycle pulse, coincident with level going low
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic pad_in,
    output logic level,
    output logic fall
);

    localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count consecutive disagreeing samples; any agreeing sample restarts the count.
    always_comb begin
        level_d = level_q;
        fall_d  = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                level_d = sync2_q;
                fall_d  = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= pad_in;
            sync2_q <= sync1_q;
            level_q <= level_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
// Sends one byte per request: inhibit (clock low), request-to-send (both low),
// then shifts data LSB first, odd parity and stop on device clock falls, and
// checks the device ACK on the 11th fall.
// Optional build macro: PS2_TX_RETRY_EN - retry a failed frame up to twice.
// Ports:
//   clk, rst                 - clock, asynchronous active-low reset
//   ps2_clk_in, ps2_data_in  - raw pad levels
//   tx_valid, tx_data        - command byte request
//   tx_ready                 - idle and able to accept a byte
//   ps2_clk_oe, ps2_data_oe  - 1 pulls the corresponding line low
//   busy                     - frame in progress
//   tx_done, tx_err          - one-cycle completion / failure pulses
//   err_code                 - last failure cause, cleared on accept
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES    = 12000,
    parameter int unsigned START_HOLD_CYCLES = 200,
    parameter int unsigned TIMEOUT_CYCLES    = 2000000,
    parameter int unsigned FILTER_LEN        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err,
    output logic [1:0] err_code
);

    localparam int unsigned MAX_IT  = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CNT_MAX = (MAX_IT > START_HOLD_CYCLES) ? MAX_IT : START_HOLD_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    logic clk_filt, clk_fall;
    logic data_filt;
    // Only the data level is sampled; its edges are not needed.
    logic data_fall_unused;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk    (clk),
        .rst    (rst),
        .pad_in (ps2_clk_in),
        .level  (clk_filt),
        .fall   (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk    (clk),
        .rst    (rst),
        .pad_in (ps2_data_in),
        .level  (data_filt),
        .fall   (data_fall_unused)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       data_q, data_d;
    logic             parity_q, parity_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             tx_ready_q, tx_ready_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             busy_q, busy_d;
    logic             tx_done_q, tx_done_d;
    logic             tx_err_q, tx_err_d;
    logic             fail;
    logic [1:0]       fail_code;
`ifdef PS2_TX_RETRY_EN
    logic [1:0]       retry_q, retry_d;
`endif

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        bit_idx_d  = bit_idx_q;
        data_d     = data_q;
        parity_d   = parity_q;
        err_code_d = err_code_q;
        data_oe_d  = data_oe_q;
        tx_done_d  = 1'b0;
        tx_err_d   = 1'b0;
        fail       = 1'b0;
        fail_code  = ERR_NONE;
`ifdef PS2_TX_RETRY_EN
        retry_d    = retry_q;
`endif

        case (state_q)
            IDLE: begin
                if (tx_valid && tx_ready_q) begin
                    data_d     = tx_data;
                    parity_d   = odd_parity(tx_data);
                    err_code_d = ERR_NONE;
                    state_d    = INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    retry_d    = 2'd0;
`endif
                end
            end
            INHIBIT: begin
                if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == CNT_W'(START_HOLD_CYCLES - 1)) begin
                    state_d = BITS;
                end
            end
            BITS: begin
                if (clk_fall) begin
                    cnt_d     = '0;
                    bit_idx_d = bit_idx_q + 4'd1;
                    // bit_idx_q counts falls already seen; this fall is number bit_idx_q+1.
                    case (bit_idx_q)
                        4'd8:    data_oe_d = ~parity_q;
                        4'd9:    data_oe_d = 1'b0;
                        4'd10: begin
                            if (!data_filt) begin
                                state_d = WAIT_IDLE;
                            end else begin
                                fail      = 1'b1;
                                fail_code = ERR_NOACK;
                            end
                        end
                        default: data_oe_d = ~data_q[bit_idx_q[2:0]];
                    endcase
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    fail      = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end
            end
            WAIT_IDLE: begin
                if (clk_filt && data_filt) begin
                    state_d   = IDLE;
                    tx_done_d = 1'b1;
                end else if (clk_fall) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    fail      = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end
            end
            ERR: begin
                state_d  = IDLE;
                tx_err_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (fail) begin
            err_code_d = fail_code;
`ifdef PS2_TX_RETRY_EN
            if (retry_q < MAX_RETRIES) begin
                retry_d = retry_q + 2'd1;
                state_d = INHIBIT;
            end else begin
                state_d = ERR;
            end
`else
            state_d = ERR;
`endif
        end

        // Every state entry restarts the shared cycle counter.
        if (state_d != state_q) begin
            cnt_d = '0;
        end
        if (state_d != BITS) begin
            bit_idx_d = '0;
        end

        // The start bit is driven from START until the first device fall.
        if (state_d == START) begin
            data_oe_d = 1'b1;
        end else if (state_d != BITS) begin
            data_oe_d = 1'b0;
        end

        clk_oe_d   = (state_d == INHIBIT) || (state_d == START);
        busy_d     = (state_d != IDLE);
        // Ready only once a full cycle has been spent in IDLE, so it rises after done/err.
        tx_ready_d = (state_d == IDLE) && (state_q == IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            data_q     <= '0;
            parity_q   <= 1'b0;
            err_code_q <= ERR_NONE;
            tx_ready_q <= 1'b1;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            busy_q     <= 1'b0;
            tx_done_q  <= 1'b0;
            tx_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            data_q     <= data_d;
            parity_q   <= parity_d;
            err_code_q <= err_code_d;
            tx_ready_q <= tx_ready_d;
            clk_oe_q   <= clk_oe_d;
            data_oe_q  <= data_oe_d;
            busy_q     <= busy_d;
            tx_done_q  <= tx_done_d;
            tx_err_q   <= tx_err_d;
        end
    end

`ifdef PS2_TX_RETRY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retry_q <= 2'd0;
        end else begin
            retry_q <= retry_d;
        end
    end
`endif

    assign tx_ready    = tx_ready_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign busy        = busy_q;
    assign tx_done     = tx_done_q;
    assign tx_err      = tx_err_q;
    assign err_code    = err_code_q;

endmodule
